// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, opcode/funct constants, the ALU operation
// selector fed to mips_alu_decoder, and the alu_control, alu_src_b and
// pc_source encodings.
package mips_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTE  = 4'd6,
      ST_ALUWB    = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_ADDIEXEC = 4'd9,
      ST_ADDIWB   = 4'd10,
      ST_JUMP     = 4'd11,
      ST_HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Selector into mips_alu_decoder: fixed ADD, fixed SUB, or decode funct.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control_if.sv
// Bundle between the multicycle controller and its datapath.
// Datapath -> controller: opcode, funct, zero.
// Controller -> datapath: all write enables, mux selects, alu_control,
// plus the debug_state / instr_done / halted status outputs.
// master = controller side, slave = datapath side.
interface mips_mc_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       ir_write;
   logic       pc_en;
   logic       i_or_d;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_control;
   logic [1:0] pc_source;
   logic [3:0] debug_state;
   logic       instr_done;
   logic       halted;

   modport master (
      input  opcode, funct, zero,
      output ir_write, pc_en, i_or_d, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source,
             debug_state, instr_done, halted
   );

   modport slave (
      output opcode, funct, zero,
      input  ir_write, pc_en, i_or_d, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source,
             debug_state, instr_done, halted
   );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder.
// Ports: alu_op (fixed ADD / fixed SUB / decode funct), funct (instr[5:0]),
// alu_control (ALU operation), illegal (funct not supported, only
// meaningful when alu_op selects funct decoding).
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       illegal
);

   // Map operation selector and funct field onto an ALU operation.
   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: begin
                  // Unknown funct: drive the all-zero code, flag illegal.
                  alu_control = 4'b0000;
                  illegal     = 1'b1;
               end
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller (lw, sw, R-type, beq, addi, j).
// Ports: clk, reset (synchronous, active-high), bus (master modport of
// mips_mc_control_if carrying opcode/funct/zero in and all control and
// status outputs out). Outputs are combinational from the state register
// (plus zero, funct and, in DECODE, opcode).
// HALT_ON_ILLEGAL: 1 = unsupported opcode/funct parks in HALT until reset,
// 0 = it retires as a NOP with instr_done.
module mips_mc_control
   import mips_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
)(
   input  logic               clk,
   input  logic               reset,
   mips_mc_control_if.master  bus
);

   state_t     state_r;
   state_t     next_state_s;
   logic [1:0] alu_op_s;
   logic       use_alu_s;
   logic [3:0] dec_alu_control_s;
   logic       funct_illegal_s;
   logic       pc_write_s;
   logic       branch_s;
   logic       ir_write_s;
   logic       i_or_d_s;
   logic       mem_write_s;
   logic       reg_write_s;
   logic       reg_dst_s;
   logic       mem_to_reg_s;
   logic       alu_src_a_s;
   logic [1:0] alu_src_b_s;
   logic [1:0] pc_source_s;
   logic       instr_done_s;

   mips_alu_decoder u_alu_decoder (
      .alu_op      (alu_op_s),
      .funct       (bus.funct),
      .alu_control (dec_alu_control_s),
      .illegal     (funct_illegal_s)
   );

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and control decode; everything not set for a state stays 0.
   always_comb begin
      next_state_s = state_r;
      alu_op_s     = ALUOP_ADD;
      use_alu_s    = 1'b0;
      pc_write_s   = 1'b0;
      branch_s     = 1'b0;
      ir_write_s   = 1'b0;
      i_or_d_s     = 1'b0;
      mem_write_s  = 1'b0;
      reg_write_s  = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = SRCB_B;
      pc_source_s  = PCSRC_ALU;
      instr_done_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            ir_write_s   = 1'b1;
            pc_write_s   = 1'b1;
            alu_src_b_s  = SRCB_FOUR;
            use_alu_s    = 1'b1;
            next_state_s = ST_DECODE;
         end
         ST_DECODE: begin
            // Branch target precomputed into ALUOut while decoding.
            alu_src_b_s = SRCB_IMM_SH;
            use_alu_s   = 1'b1;
            case (bus.opcode)
               OP_LW, OP_SW: next_state_s = ST_MEMADR;
               OP_RTYPE:     next_state_s = ST_EXECUTE;
               OP_BEQ:       next_state_s = ST_BRANCH;
               OP_ADDI:      next_state_s = ST_ADDIEXEC;
               OP_J:         next_state_s = ST_JUMP;
               default: begin
                  if (HALT_ON_ILLEGAL) begin
                     next_state_s = ST_HALT;
                  end else begin
                     next_state_s = ST_FETCH;
                     instr_done_s = 1'b1;
                  end
               end
            endcase
         end
         ST_MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_IMM;
            use_alu_s   = 1'b1;
            if (bus.opcode == OP_SW) begin
               next_state_s = ST_MEMWRITE;
            end else begin
               next_state_s = ST_MEMREAD;
            end
         end
         ST_MEMREAD: begin
            i_or_d_s     = 1'b1;
            next_state_s = ST_MEMWB;
         end
         ST_MEMWB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_MEMWRITE: begin
            i_or_d_s     = 1'b1;
            mem_write_s  = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_EXECUTE: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = SRCB_B;
            alu_op_s    = ALUOP_FUNCT;
            use_alu_s   = 1'b1;
            if (funct_illegal_s) begin
               if (HALT_ON_ILLEGAL) begin
                  next_state_s = ST_HALT;
               end else begin
                  next_state_s = ST_FETCH;
                  instr_done_s = 1'b1;
               end
            end else begin
               next_state_s = ST_ALUWB;
            end
         end
         ST_ALUWB: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a_s  = 1'b1;
            alu_src_b_s  = SRCB_B;
            alu_op_s     = ALUOP_SUB;
            use_alu_s    = 1'b1;
            pc_source_s  = PCSRC_ALUOUT;
            branch_s     = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_ADDIEXEC: begin
            alu_src_a_s  = 1'b1;
            alu_src_b_s  = SRCB_IMM;
            use_alu_s    = 1'b1;
            next_state_s = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_JUMP: begin
            pc_source_s  = PCSRC_JUMP;
            pc_write_s   = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = ST_FETCH;
         end
         ST_HALT: next_state_s = ST_HALT;
         default: begin
            // Unused encodings are treated like an illegal instruction.
            if (HALT_ON_ILLEGAL) begin
               next_state_s = ST_HALT;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
      endcase
   end

   assign bus.ir_write    = ir_write_s;
   assign bus.pc_en       = pc_write_s | (branch_s & bus.zero);
   assign bus.i_or_d      = i_or_d_s;
   assign bus.mem_write   = mem_write_s;
   assign bus.reg_write   = reg_write_s;
   assign bus.reg_dst     = reg_dst_s;
   assign bus.mem_to_reg  = mem_to_reg_s;
   assign bus.alu_src_a   = alu_src_a_s;
   assign bus.alu_src_b   = alu_src_b_s;
   assign bus.alu_control = use_alu_s ? dec_alu_control_s : 4'b0000;
   assign bus.pc_source   = pc_source_s;
   assign bus.debug_state = state_r;
   assign bus.instr_done  = instr_done_s;
   assign bus.halted      = (state_r == ST_HALT);

endmodule
